// File: rtl/nios_debug_ocimem_ctrl.sv
// Debug-memory access controller: turns decoded JTAG ocimem commands into single-word Avalon-MM accesses.
// Optional `define OCIMEM_TIMEOUT_EN aborts accesses stalled on avm_waitrequest for TIMEOUT cycles.
module nios_debug_ocimem_ctrl #(
    parameter int ADDR_W  = 8,
    parameter int TIMEOUT = 255
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [37:0]       jdo,
    input  logic              take_action_ocimem_a,
    input  logic              take_no_action_ocimem_a,
    input  logic              take_action_ocimem_b,
    output logic [ADDR_W+1:0] avm_address,
    output logic              avm_read,
    output logic              avm_write,
    output logic [31:0]       avm_writedata,
    input  logic [31:0]       avm_readdata,
    input  logic              avm_waitrequest,
    output logic [31:0]       MonDReg,
    output logic              monitor_ready,
    output logic              monitor_error
);

    typedef enum logic [1:0] {
        IDLE,
        RD,
        WR,
        DONE
    } state_t;

    localparam logic [ADDR_W-1:0] ADDR_ONE = ADDR_W'(1);

    state_t            state;
    logic [ADDR_W-1:0] addr;
    logic              any_strobe;
    logic              unused;

`ifdef OCIMEM_TIMEOUT_EN
    localparam logic [15:0] TO_LAST = 16'(TIMEOUT - 1);
    logic [15:0] tmo_cnt;
`endif

    assign any_strobe  = take_action_ocimem_a | take_action_ocimem_b
                       | take_no_action_ocimem_a;
    assign avm_address = {addr, 2'b00};
    assign unused      = ^{jdo[37], jdo[2:0]};

    always_ff @(posedge clk) begin
        if (reset) begin
            state         <= IDLE;
            addr          <= '0;
            avm_read      <= 1'b0;
            avm_write     <= 1'b0;
            avm_writedata <= '0;
            MonDReg       <= '0;
            monitor_ready <= 1'b0;
            monitor_error <= 1'b0;
`ifdef OCIMEM_TIMEOUT_EN
            tmo_cnt       <= '0;
`endif
        end else begin
            unique case (state)
                IDLE: begin
`ifdef OCIMEM_TIMEOUT_EN
                    if (any_strobe) tmo_cnt <= '0;
`endif
                    if (take_action_ocimem_a) begin
                        addr          <= jdo[ADDR_W+16:17];
                        monitor_ready <= 1'b0;
                        // an explicit clear outranks the collision error
                        if (jdo[36])
                            monitor_error <= 1'b0;
                        else if (take_action_ocimem_b | take_no_action_ocimem_a)
                            monitor_error <= 1'b1;
                        if (jdo[35]) begin
                            avm_read <= 1'b1;
                            state    <= RD;
                        end
                    end else if (take_action_ocimem_b) begin
                        if (take_no_action_ocimem_a) monitor_error <= 1'b1;
                        avm_writedata <= jdo[34:3];
                        avm_write     <= 1'b1;
                        monitor_ready <= 1'b0;
                        state         <= WR;
                    end else if (take_no_action_ocimem_a) begin
                        avm_read      <= 1'b1;
                        monitor_ready <= 1'b0;
                        state         <= RD;
                    end
                end
                RD, WR: begin
                    if (any_strobe) monitor_error <= 1'b1;
                    if (!avm_waitrequest) begin
                        MonDReg   <= (state == RD) ? avm_readdata : avm_writedata;
                        addr      <= addr + ADDR_ONE;
                        avm_read  <= 1'b0;
                        avm_write <= 1'b0;
                        state     <= DONE;
                    end
`ifdef OCIMEM_TIMEOUT_EN
                    else if (tmo_cnt == TO_LAST) begin
                        MonDReg       <= 32'hDEADBEEF;
                        monitor_error <= 1'b1;
                        avm_read      <= 1'b0;
                        avm_write     <= 1'b0;
                        state         <= DONE;
                    end else begin
                        tmo_cnt <= tmo_cnt + 16'd1;
                    end
`endif
                end
                DONE: begin
                    if (any_strobe) monitor_error <= 1'b1;
                    monitor_ready <= 1'b1;
                    state         <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
